mul_shift_add: RTL and testbench

Multi-cycle 32×32→32 unsigned multiplier built on the team's 32-bit combinational `Add` adder. It sits directly upstream of that adder: each cycle it presents accumulator and shifted multiplicand as adder operands and registers the sum. It accepts operands over a valid/ready handshake and returns the low 32 product bits, mod 2^32, over a second valid/ready handshake. Run length is data-dependent, with early termination on the multiplier's highest set bit.

---
 rtl/alu_pkg.sv | 6 +
 rtl/Add.sv | 10 +
 rtl/mul_shift_add.sv | 85 ++++++++
 tb/tb_mul_shift_add.sv | 136 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: widths and multiplier FSM states shared by the ALU stages
package alu_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 5;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mul_state_t;
endpackage

// File: rtl/Add.sv
// Add: 32-bit combinational adder, carry out discarded
module Add
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);
    assign sum = a + b;
endmodule

// File: rtl/mul_shift_add.sv
// mul_shift_add: multi-cycle shift-and-add multiplier returning (a*b) mod 2^32
module mul_shift_add
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] product,
    output logic             busy
);
    mul_state_t       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
    logic [WIDTH-1:0] product_q, product_d, sum;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last;

    Add u_add (.a(acc_q), .b(mcand_q), .sum(sum));

    // RUN ends once no set multiplier bits remain or all bit positions are consumed
    assign last      = (mplier_q >> 1) == '0 || cnt_q == CNT_W'(WIDTH - 1);
    assign in_ready  = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign busy      = state_q != IDLE;
    assign product   = product_q;

    // next state: accept loads operands, RUN shifts and accumulates, DONE waits for the consumer
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d  = RUN;
                acc_d    = '0;
                mcand_d  = a;
                mplier_d = b;
                cnt_d    = '0;
            end
            RUN: begin
                acc_d    = mplier_q[0] ? sum : acc_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d   = DONE;
                    product_d = acc_d;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d   = IDLE;
            product_d = product_q;
        end
    end

    // state and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end
endmodule

// File: tb/tb_mul_shift_add.sv
// tb_mul_shift_add: directed and random checks against an arithmetic reference model
module tb_mul_shift_add;
    logic        clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
    logic [31:0] a = 0, b = 0;
    logic        in_ready, out_valid, busy;
    logic [31:0] product;
    int          n_checks = 0, n_pass = 0;

    always #5 clk = ~clk;

    mul_shift_add dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic int ref_len(input logic [31:0] y);
        int n = 1;
        for (int i = 0; i < 32; i++) if (y[i]) n = i + 1;
        return n;
    endfunction

    task automatic start(input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        check("in_ready_before", in_ready, 1);
        a = x; b = y; in_valid = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; a = $urandom; b = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic do_op(input logic [31:0] x, input logic [31:0] y, input int hold, input string tag);
        logic [31:0] exp;
        int lat;
        exp = x * y;
        start(x, y);
        wait_done(lat);
        check({tag, "_len"}, 32'(lat), 32'(ref_len(y)));
        check({tag, "_prod"}, product, exp);
        check({tag, "_busy"}, busy, 1);
        repeat (hold) begin
            in_valid = 1;
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_prod"}, product, exp);
            check({tag, "_hold_ready"}, in_ready, 0);
        end
        in_valid = 0; out_ready = 1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 0;
        check({tag, "_idle"}, in_ready, 1);
        check({tag, "_valid_low"}, out_valid, 0);
        check({tag, "_prod_kept"}, product, exp);
    endtask

    initial begin
        logic seen;
        int lat;
        repeat (2) @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_prod", product, 0);
        rst_n = 1;
        do_op(32'd3, 32'd5, 0, "3x5");
        do_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, "wrap");
        do_op(32'h12345678, 32'h0, 0, "b_zero");
        do_op(32'h0, 32'h80000000, 0, "b_msb");
        do_op(32'd7, 32'd6, 10, "hold");
        start(32'h10, 32'hFF);
        @(posedge clk);
        @(negedge clk);
        flush = 1;
        @(posedge clk);
        @(negedge clk);
        flush = 0;
        check("flush_idle", in_ready, 1);
        check("flush_prod", product, 42);
        seen = 0;
        repeat (12) begin
            @(posedge clk);
            @(negedge clk);
            seen |= out_valid;
        end
        check("flush_no_valid", seen, 0);
        do_op(32'd2, 32'd2, 0, "after_flush");
        @(negedge clk);
        a = 5; b = 5; in_valid = 1; flush = 1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 0; flush = 0;
        check("flush_accept_idle", in_ready, 1);
        check("flush_accept_busy", busy, 0);
        start(32'h10, 32'hFF);
        @(posedge clk);
        @(negedge clk);
        rst_n = 0;
        #1;
        check("rst_run_valid", out_valid, 0);
        check("rst_run_prod", product, 0);
        check("rst_run_ready", in_ready, 1);
        check("rst_run_busy", busy, 0);
        @(negedge clk);
        rst_n = 1;
        start(32'd3, 32'd3);
        wait_done(lat);
        check("pre_rst_done", out_valid, 1);
        rst_n = 0;
        #1;
        check("rst_done_valid", out_valid, 0);
        check("rst_done_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1;
        do_op(32'd9, 32'd9, 0, "9x9");
        for (int i = 0; i < 25; i++)
            do_op($urandom, $urandom >> $urandom_range(0, 32), $urandom_range(0, 3), "rand");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
